imm_decode_pipe: RTL and testbench

- Registered, parametrised successor to the combinational immediate decoder.
- Accepts a 32-bit RV32I/RV64I instruction over a valid/ready handshake and classifies its format.
- Produces the sign- or zero-extended immediate at width XLEN, with one cycle of latency.
- Sits between fetch and the register-read/control stage; a 2-entry skid buffer keeps full throughput under backpressure.

---
 rtl/imm_decode_pipe.sv | 155 +++++++++++++++
 tb/tb_imm_decode_pipe.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_pipe.sv
// Registered RV32I/RV64I immediate decoder with a valid/ready handshake and 2-entry skid buffer.
// Optional performance counters are enabled by defining IMM_DECODE_PERF_EN.
module imm_decode_pipe #(
  parameter int unsigned XLEN         = 32,
  parameter bit          CSR_ADDR_IMM = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_insn,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
`ifdef IMM_DECODE_PERF_EN
  ,
  output logic [31:0]     perf_insn_cnt,
  output logic [15:0]     perf_illegal_cnt
`endif
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_decode_pipe: XLEN must be 32 or 64");
  end

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_SYS = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [31:0]     insn;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            ill;
  } entry_t;

  entry_t dec;
  entry_t m_q;
  entry_t k_q;
  logic   m_valid_q;
  logic   k_valid_q;
  logic   acc;
  logic   drain;
  logic [31:0] imm32;

  // Decode
  always_comb begin
    dec.fmt = FMT_ILL;
    imm32   = '0;
    if (in_insn[1:0] == 2'b11) begin
      case (in_insn[6:0])
        7'b0110111, 7'b0010111: begin
          dec.fmt = FMT_U;
          imm32   = {in_insn[31:12], 12'b0};
        end
        7'b1101111: begin
          dec.fmt = FMT_J;
          imm32   = {{11{in_insn[31]}}, in_insn[31], in_insn[19:12], in_insn[20],
                     in_insn[30:21], 1'b0};
        end
        7'b1100111, 7'b0010011, 7'b0000011, 7'b0001111: begin
          dec.fmt = FMT_I;
          imm32   = {{20{in_insn[31]}}, in_insn[31:20]};
        end
        7'b1100011: begin
          dec.fmt = FMT_B;
          imm32   = {{19{in_insn[31]}}, in_insn[31], in_insn[7], in_insn[30:25],
                     in_insn[11:8], 1'b0};
        end
        7'b0100011: begin
          dec.fmt = FMT_S;
          imm32   = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
        end
        7'b1110011: begin
          dec.fmt = FMT_SYS;
          imm32   = CSR_ADDR_IMM ? {20'b0, in_insn[31:20]} : {27'b0, in_insn[19:15]};
        end
        7'b0110011: begin
          dec.fmt = FMT_R;
          imm32   = '0;
        end
        default: begin
          dec.fmt = FMT_ILL;
          imm32   = '0;
        end
      endcase
    end
    dec.insn = in_insn;
    dec.ill  = (dec.fmt == FMT_ILL);
    // Bit 31 of imm32 is zero for SYS/R/illegal, so one sign extension covers every format.
    dec.imm  = XLEN'({{32{imm32[31]}}, imm32});
  end

  assign in_ready = !k_valid_q;
  assign acc      = in_valid && !k_valid_q;
  assign drain    = m_valid_q && out_ready;

  // K is only ever occupied while M is occupied, so a drain with K valid never coincides with an accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q       <= '0;
      k_q       <= '0;
      m_valid_q <= 1'b0;
      k_valid_q <= 1'b0;
    end else if (drain) begin
      if (k_valid_q) begin
        m_q       <= k_q;
        k_valid_q <= 1'b0;
      end else if (acc) begin
        m_q       <= dec;
      end else begin
        m_valid_q <= 1'b0;
      end
    end else if (acc) begin
      if (!m_valid_q) begin
        m_q       <= dec;
        m_valid_q <= 1'b1;
      end else begin
        k_q       <= dec;
        k_valid_q <= 1'b1;
      end
    end
  end

  assign out_valid   = m_valid_q;
  assign out_insn    = m_q.insn;
  assign out_imm     = m_q.imm;
  assign out_fmt     = m_q.fmt;
  assign out_illegal = m_q.ill;

`ifdef IMM_DECODE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_insn_cnt    <= '0;
      perf_illegal_cnt <= '0;
    end else if (acc) begin
      perf_insn_cnt <= perf_insn_cnt + 32'd1;
      if (dec.ill && perf_illegal_cnt != 16'hFFFF) begin
        perf_illegal_cnt <= perf_illegal_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Directed self-checking bench for imm_decode_pipe (XLEN=32, CSR address immediates).
module tb_imm_decode_pipe;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_insn;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_insn;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;
`ifdef IMM_DECODE_PERF_EN
  logic [31:0]     perf_insn_cnt;
  logic [15:0]     perf_illegal_cnt;
`endif

  int total = 0;
  int bad   = 0;

  imm_decode_pipe #(
    .XLEN         (XLEN),
    .CSR_ADDR_IMM (1'b1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_insn          (in_insn),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_insn         (out_insn),
    .out_imm          (out_imm),
    .out_fmt          (out_fmt),
    .out_illegal      (out_illegal)
`ifdef IMM_DECODE_PERF_EN
    ,
    .perf_insn_cnt    (perf_insn_cnt),
    .perf_illegal_cnt (perf_illegal_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single transfer into an idle pipe with out_ready high; called at a negedge.
  task automatic vec(input string tag, input logic [31:0] insn, input logic [2:0] f,
                     input logic [31:0] imm, input logic ill);
    in_valid  = 1'b1;
    in_insn   = insn;
    out_ready = 1'b1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_insn  = '0;
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".insn"}, 64'(out_insn), 64'(insn));
    check({tag, ".fmt"}, 64'(out_fmt), 64'(f));
    check({tag, ".imm"}, 64'(out_imm), 64'(imm));
    check({tag, ".ill"}, 64'(out_illegal), 64'(ill));
    @(negedge clk);
    check({tag, ".drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_insn   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.ready", 64'(in_ready), 64'd1);
    check("rst.imm", 64'(out_imm), 64'd0);
    check("rst.insn", 64'(out_insn), 64'd0);
    check("rst.fmt", 64'(out_fmt), 64'd0);
    check("rst.ill", 64'(out_illegal), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Illegal encodings first so the perf counters are easy to predict
    vec("ill7f", 32'h0000007F, 3'd7, 32'h0, 1'b1);
    vec("ill10", 32'h00000010, 3'd7, 32'h0, 1'b1);
`ifdef IMM_DECODE_PERF_EN
    check("perf.insn2", 64'(perf_insn_cnt), 64'd2);
    check("perf.ill2", 64'(perf_illegal_cnt), 64'd2);
`endif

    vec("lui",   32'h123450B7, 3'd4, 32'h12345000, 1'b0);
    vec("auipc", 32'hFFFFF097, 3'd4, 32'hFFFFF000, 1'b0);
    vec("addi",  32'hFFF00093, 3'd1, 32'hFFFFFFFF, 1'b0);
    vec("beq",   32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 1'b0);
    vec("csrrw", 32'h30029073, 3'd6, 32'h00000300, 1'b0);
    vec("sw",    32'h00112623, 3'd2, 32'h0000000C, 1'b0);
    vec("jalp",  32'h008000EF, 3'd5, 32'h00000008, 1'b0);
    vec("jaln",  32'hFFDFF0EF, 3'd5, 32'hFFFFFFFC, 1'b0);
    vec("add",   32'h002081B3, 3'd0, 32'h0, 1'b0);

    // Back-to-back with no backpressure: zero bubbles
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_insn   = 32'h123450B7;
    @(negedge clk);
    check("b2b.v1", 64'(out_valid), 64'd1);
    check("b2b.i1", 64'(out_insn), 64'h123450B7);
    in_insn = 32'hFFF00093;
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b.v2", 64'(out_valid), 64'd1);
    check("b2b.i2", 64'(out_insn), 64'hFFF00093);
    check("b2b.m2", 64'(out_imm), 64'hFFFFFFFF);
    @(negedge clk);
    check("b2b.empty", 64'(out_valid), 64'd0);

    // Backpressure: A into M, B into skid, C held off
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_insn   = 32'hFFF00093;
    @(negedge clk);
    check("bp.rdyA", 64'(in_ready), 64'd1);
    in_insn = 32'h123450B7;
    @(negedge clk);
    check("bp.rdyB", 64'(in_ready), 64'd0);
    check("bp.headA", 64'(out_insn), 64'hFFF00093);
    in_insn = 32'hFE000EE3;
    @(negedge clk);
    check("bp.stallV", 64'(out_valid), 64'd1);
    check("bp.stallI", 64'(out_insn), 64'hFFF00093);
    check("bp.stallM", 64'(out_imm), 64'hFFFFFFFF);
    check("bp.stallR", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.outB", 64'(out_insn), 64'h123450B7);
    check("bp.fmtB", 64'(out_fmt), 64'd4);
    check("bp.rdyUp", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp.outC", 64'(out_insn), 64'hFE000EE3);
    check("bp.immC", 64'(out_imm), 64'hFFFFFFFC);
    check("bp.vC", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("bp.empty", 64'(out_valid), 64'd0);

    // Reset with M and K full, plus a competing handshake
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_insn   = 32'h002081B3;
    @(negedge clk);
    in_insn = 32'h00112623;
    @(negedge clk);
    check("rf.full", 64'(in_ready), 64'd0);
    check("rf.v", 64'(out_valid), 64'd1);
    reset     = 1'b1;
    in_insn   = 32'h123450B7;
    out_ready = 1'b1;
    @(negedge clk);
    check("rf.valid", 64'(out_valid), 64'd0);
    check("rf.ready", 64'(in_ready), 64'd1);
    check("rf.insn", 64'(out_insn), 64'd0);
    check("rf.imm", 64'(out_imm), 64'd0);
`ifdef IMM_DECODE_PERF_EN
    check("rf.pinsn", 64'(perf_insn_cnt), 64'd0);
    check("rf.pill", 64'(perf_illegal_cnt), 64'd0);
`endif
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rf.gone", 64'(out_valid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
